// File: rtl/fetch_queue.sv
// Instruction fetch queue: prefetches ROM words into a DEPTH-entry circular buffer
// ahead of decode. Optional empty-queue bypass selected by FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [7:0]                 o_rom_addr,
    input  logic [31:0]                i_rom_data,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    input  logic                       i_stall,
    output logic                       o_valid,
    output logic [31:0]                o_instr,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_npc,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fpc_q, fpc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic        q_nonempty;
    logic        q_full;
    logic        bypass_act;
    logic        deq;
    logic        bypass_take;
    logic        enq;
    logic        wr_en;
    logic [31:0] head_instr;
    logic [31:0] head_pc;

    assign q_nonempty = (count_q != '0);
    assign q_full     = (count_q == CW'(DEPTH));
    assign head_instr = instr_mem[rd_ptr_q];
    assign head_pc    = pc_mem[rd_ptr_q];
    assign o_rom_addr = fpc_q[7:0];
    assign o_count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_act = !q_nonempty;
`else
    assign bypass_act = 1'b0;
`endif

    // Outputs come from the head entry (or the bypassed ROM word), never from stall/redirect.
    always_comb begin
        o_valid = 1'b0;
        o_instr = 32'd0;
        o_pc    = 32'd0;
        o_npc   = 32'd0;
        if (q_nonempty) begin
            o_valid = 1'b1;
            o_instr = head_instr;
            o_pc    = head_pc;
            o_npc   = head_pc + 32'd1;
        end else if (bypass_act) begin
            o_valid = 1'b1;
            o_instr = i_rom_data;
            o_pc    = fpc_q;
            o_npc   = fpc_q + 32'd1;
        end
    end

    always_comb begin
        deq         = q_nonempty && !i_stall && !i_redirect;
        bypass_take = bypass_act && !i_stall && !i_redirect;
        enq         = !i_redirect && (!q_full || deq);
        // A consumed bypass word advances fpc but never lands in the queue.
        wr_en       = enq && !bypass_take;

        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (i_redirect) begin
            fpc_d    = i_redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                fpc_d = fpc_q + 32'd1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            instr_mem[wr_ptr_q] <= i_rom_data;
            pc_mem[wr_ptr_q]    <= fpc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// stall/redirect/reset traffic, checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  o_rom_addr;
    logic [31:0] i_rom_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_stall;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_npc;
    logic [2:0]  o_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mq[$];
    logic [31:0] m_fpc;
    bit          m_ok = 1'b0;

    always #5 clk = ~clk;

    // ROM[n] = n + 100
    assign i_rom_data = 32'(o_rom_addr) + 32'd100;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (i_rom_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_stall       (i_stall),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_npc         (o_npc),
        .o_count       (o_count)
    );

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return {24'd0, pc[7:0]} + 32'd100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, apply inputs for one edge, advance the model.
    task automatic step(input bit rst, input bit rd, input logic [31:0] rpc, input bit st);
        bit          e_v;
        logic [31:0] e_pc;
        bit          deq;
        bit          enq;
        int          sz;
        if (m_ok) begin
            if (mq.size() > 0) begin
                e_v  = 1'b1;
                e_pc = mq[0];
            end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
                e_v  = 1'b1;
                e_pc = m_fpc;
`else
                e_v  = 1'b0;
                e_pc = 32'd0;
`endif
            end
            chk("valid",    32'(o_valid),    32'(e_v));
            chk("instr",    o_instr,         e_v ? rom(e_pc) : 32'd0);
            chk("pc",       o_pc,            e_pc);
            chk("npc",      o_npc,           e_v ? e_pc + 32'd1 : 32'd0);
            chk("count",    32'(o_count),    32'(mq.size()));
            chk("rom_addr", 32'(o_rom_addr), {24'd0, m_fpc[7:0]});
        end
        reset         = rst;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        i_stall       = st;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_fpc = RESET_PC;
            m_ok  = 1'b1;
        end else if (rd) begin
            mq.delete();
            m_fpc = rpc;
        end else if (m_ok) begin
            sz = mq.size();
`ifdef FETCH_QUEUE_BYPASS_EN
            if (sz == 0 && !st) begin
                m_fpc = m_fpc + 32'd1;
            end else begin
`else
            begin
`endif
                deq = (sz > 0) && !st;
                enq = (sz < DEPTH) || deq;
                if (deq) void'(mq.pop_front());
                if (enq) begin
                    mq.push_back(m_fpc);
                    m_fpc = m_fpc + 32'd1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        i_stall       = 1'b0;
        @(negedge clk);

        // Streaming from reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // Stall from reset until saturation, then drain
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // Redirect with three entries queued
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 1, 32'h40, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Reset wins over a concurrent redirect
        step(1, 1, 32'h1234, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Fill at fpc=255, then dequeue each cycle across the 8-bit address wrap
        step(0, 1, 32'd255, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        // 32-bit fpc wrap
        step(0, 1, 32'hFFFF_FFFE, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit          r_rst;
            bit          r_rd;
            logic [31:0] r_pc;
            bit          r_st;
            r_rst = ($urandom % 64) == 0;
            r_rd  = ($urandom % 12) == 0;
            r_pc  = ($urandom % 3 == 0) ? (32'hFFFF_FFFC + 32'($urandom % 4))
                                        : (($urandom % 2 == 0) ? 32'(252 + $urandom % 4) : $urandom);
            r_st  = ($urandom % 3) == 0;
            step(r_rst, r_rd, r_pc, r_st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
